// File: rtl/mult_chk_pkg.sv
// Shared types and sizing helpers for the exhaustive multiplier checker.
// Optional first-mismatch capture is enabled with MULTCHK_FIRST_ERR_EN.
package mult_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH  = 2;
    localparam int unsigned DEF_PROD_W = 2 * DEF_WIDTH;
    localparam int unsigned DEF_ERR_W  = 2 * DEF_WIDTH + 1;

    // Number of operand pairs swept for a given operand width.
    function automatic longint unsigned nvec(input int unsigned width);
        return 64'd1 << (2 * width);
    endfunction

    function automatic int unsigned prod_w(input int unsigned width);
        return 2 * width;
    endfunction

    // One extra bit so a full-sweep failure count never saturates.
    function automatic int unsigned err_w(input int unsigned width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/mult_chk_delay.sv
// Fixed-depth shift register carrying the {valid, a, b, golden} check tag.
// DEPTH=0 degenerates into a wire.
module mult_chk_delay #(
    parameter int DEPTH = 0,
    parameter int DW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;
            assign o_q = i_d;
        end else begin : g_pipe
            logic [DW-1:0] r_stage [DEPTH];

            // Shift the tag one stage per clock; reset flushes all stages.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mult_exhaustive_checker.sv
// Sweeps every A x B pair into a candidate multiplier and counts wrong products.
// Define MULTCHK_FIRST_ERR_EN to capture the operands/product of the first mismatch.
module mult_exhaustive_checker
    import mult_chk_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int LAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    input  logic [2*WIDTH-1:0]   dut_p,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     err_count,
    output logic                 pass,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b,
    output logic [2*WIDTH-1:0]   first_err_p
);

    localparam int PW  = prod_w(WIDTH);
    localparam int EW  = err_w(WIDTH);
    localparam int VW  = 2 * WIDTH;
    localparam int DCW = (LAT > 0) ? $clog2(LAT + 1) : 1;
`ifdef MULTCHK_FIRST_ERR_EN
    localparam int TW  = 1 + 2 * WIDTH + PW;
`else
    localparam int TW  = 1 + PW;
`endif

    localparam logic [VW-1:0]  VC_LAST    = {VW{1'b1}};
    localparam logic [VW-1:0]  VC_ONE     = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]  ERR_ONE    = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [DCW-1:0] DRAIN_ONE  = {{(DCW-1){1'b0}}, 1'b1};
    localparam logic [DCW-1:0] DRAIN_LAST = (LAT > 0) ? DCW'(LAT - 1) : {DCW{1'b0}};

    state_t         r_state;
    state_t         w_next_state;
    logic           w_accept;
    logic [VW-1:0]  r_vc;
    logic [DCW-1:0] r_drain;
    logic [EW-1:0]  r_err;

    logic [PW-1:0]  w_a_ext;
    logic [PW-1:0]  w_b_ext;
    logic [PW-1:0]  w_golden;
    logic           w_valid_in;
    logic [TW-1:0]  w_tag_in;
    logic [TW-1:0]  w_tag_out;
    logic           w_d_valid;
    logic [PW-1:0]  w_d_golden;
    logic           w_mismatch;

    // Golden product is formed from the registered operands actually on the DUT.
    assign w_a_ext    = {{WIDTH{1'b0}}, r_vc[WIDTH-1:0]};
    assign w_b_ext    = {{WIDTH{1'b0}}, r_vc[VW-1:WIDTH]};
    assign w_golden   = w_a_ext * w_b_ext;
    assign w_valid_in = (r_state == SWEEP);

`ifdef MULTCHK_FIRST_ERR_EN
    logic [WIDTH-1:0] w_d_a;
    logic [WIDTH-1:0] w_d_b;
    assign w_tag_in = {w_valid_in, r_vc[WIDTH-1:0], r_vc[VW-1:WIDTH], w_golden};
    assign {w_d_valid, w_d_a, w_d_b, w_d_golden} = w_tag_out;
`else
    assign w_tag_in = {w_valid_in, w_golden};
    assign {w_d_valid, w_d_golden} = w_tag_out;
`endif

    mult_chk_delay #(
        .DEPTH (LAT),
        .DW    (TW)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .i_d (w_tag_in),
        .o_q (w_tag_out)
    );

    assign w_mismatch = w_d_valid && (dut_p != w_d_golden);

    // Next-state decode; start is only honoured when not busy.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next_state = SWEEP;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = r_state;
                end
            end
            SWEEP: begin
                if (r_vc == VC_LAST) begin
                    if (LAT > 0) begin
                        w_next_state = DRAIN;
                    end else begin
                        w_next_state = DONE;
                    end
                end else begin
                    w_next_state = SWEEP;
                end
            end
            DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, vector counter, drain counter and mismatch count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_vc    <= '0;
            r_drain <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_vc    <= '0;
                r_drain <= '0;
                r_err   <= '0;
            end else begin
                // The counter parks on the all-ones vector instead of wrapping.
                if ((r_state == SWEEP) && (r_vc != VC_LAST)) begin
                    r_vc <= r_vc + VC_ONE;
                end
                if (r_state == DRAIN) begin
                    r_drain <= r_drain + DRAIN_ONE;
                end else begin
                    r_drain <= '0;
                end
                if (w_mismatch) begin
                    r_err <= r_err + ERR_ONE;
                end
            end
        end
    end

`ifdef MULTCHK_FIRST_ERR_EN
    logic             r_fe_valid;
    logic [WIDTH-1:0] r_fe_a;
    logic [WIDTH-1:0] r_fe_b;
    logic [PW-1:0]    r_fe_p;

    // Latch the first mismatch of a sweep; later ones are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fe_valid <= 1'b0;
            r_fe_a     <= '0;
            r_fe_b     <= '0;
            r_fe_p     <= '0;
        end else if (w_accept) begin
            r_fe_valid <= 1'b0;
            r_fe_a     <= '0;
            r_fe_b     <= '0;
            r_fe_p     <= '0;
        end else if (w_mismatch && !r_fe_valid) begin
            r_fe_valid <= 1'b1;
            r_fe_a     <= w_d_a;
            r_fe_b     <= w_d_b;
            r_fe_p     <= dut_p;
        end
    end

    assign first_err_a = r_fe_a;
    assign first_err_b = r_fe_b;
    assign first_err_p = r_fe_p;
`else
    assign first_err_a = '0;
    assign first_err_b = '0;
    assign first_err_p = '0;
`endif

    assign dut_a     = r_vc[WIDTH-1:0];
    assign dut_b     = r_vc[VW-1:WIDTH];
    assign busy      = (r_state == SWEEP) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign err_count = r_err;
    assign pass      = done && (r_err == {EW{1'b0}});

endmodule
